sar_seq_ctrl: RTL and testbench
===============================

Name: sar_seq_ctrl

Overview:
Parametrised multi-channel SAR conversion sequencer. It is the successor of the single-channel SAR controller and sits between the ADC register wrapper and the analog ADC macro. The block runs the successive-approximation bit search and sequences conversions across a channel mask in single, scan-once or continuous modes. It also does power-of-two oversampling/averaging, window-compares each result and buffers results in a small FIFO for the bus side.

Parameters:
SIZE, 12, conversion width in bits
NCH, 4, number of analog channels (2..16)
CH_W, 2, channel index width, = clog2(NCH)
FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset, asynchronous, active-low
en  in  1  block enable; low aborts any operation
start  in  1  start request, acted on in IDLE only
mode  in  2  00 single, 01 scan-once, 10 continuous scan, 11 treated as 01
ch_mask  in  NCH  channels to convert
swidth  in  4  sample phase length minus 1, in cycles
avg_log2  in  2  number of samples averaged = 2^avg_log2
thr_lo  in  SIZE  window low threshold
thr_hi  in  SIZE  window high threshold
cmp  in  1  comparator output; 1 = input >= dac_val
sample_n  out  1  0 during sampling (hold when 1)
dac_rst  out  1  DAC reset, high during sampling
dac_val  out  SIZE  DAC trial code
ch_sel  out  CH_W  analog mux select
busy  out  1  high whenever not IDLE
eos  out  1  one-cycle pulse at end of sequence
win  out  1  one-cycle pulse: result outside window
ovf  out  1  one-cycle pulse: result dropped, FIFO full
fifo_rd  in  1  pop head entry
fifo_data  out  SIZE  head result (show-ahead); 0 when empty
fifo_ch  out  CH_W  channel of head result; 0 when empty
fifo_empty  out  1  FIFO empty
fifo_full  out  1  FIFO full
fifo_level  out  clog2(FIFO_DEPTH)+1  entry count

Behaviour:
- Reset: state IDLE. sample_n=1, dac_rst=0, dac_val=0, ch_sel=0, busy=0, eos=win=ovf=0, FIFO cleared (fifo_empty=1, level=0, data/ch=0).
- IDLE -> SAMPLE requires start=1, en=1 and ch_mask!=0. Otherwise start is ignored. start is also ignored while busy.
- On the start cycle, latch mode, ch_mask, swidth and avg_log2. ch_sel is set to the lowest set mask bit. The accumulator and sample counter are cleared. Mode single converts only that lowest channel.
- SAMPLE: lasts swidth+1 cycles. sample_n=0, dac_rst=1, dac_val=0.
- CONVERT: lasts SIZE cycles, with sample_n=1 and dac_rst=0. Cycle k (k=0..SIZE-1) drives dac_val = partial | (1<<(SIZE-1-k)). At the end of the cycle the bit is kept if cmp=1, cleared otherwise.
- After CONVERT, the code is added to the accumulator (width SIZE+3, no overflow possible). If fewer than 2^avg_log2 samples have been taken, return to SAMPLE on the same channel. Otherwise go to STORE.
- STORE (1 cycle):
  - result = acc >> avg_log2, truncated (no rounding).
  - win=1 if result < thr_lo or result > thr_hi. Thresholds are sampled this cycle. If thr_lo > thr_hi, every result flags.
  - Push {result, ch_sel} to the FIFO.
  - Next channel = next higher set bit of the latched mask.
  - If there is none: eos=1 in this cycle. Single/scan-once -> IDLE. Continuous -> SAMPLE at the lowest set bit.
  - Otherwise -> SAMPLE at the next channel.
- Latency per result: 2^avg_log2*(swidth+1+SIZE)+1 cycles, measured from the first SAMPLE cycle to the STORE cycle inclusive.
- FIFO behaviour:
  - Push when full and no fifo_rd in that cycle: entry dropped, ovf=1, contents unchanged.
  - Push with fifo_rd while full: both take effect, level stays FIFO_DEPTH.
  - fifo_rd while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop is visible on fifo_data the next cycle.
- win and ovf are both asserted for a dropped result if it is out of window.
- en=0 in any non-IDLE state: next cycle IDLE, no push, no eos, accumulator cleared, outputs back to IDLE values. FIFO contents are retained and fifo_rd still works while en=0.
- Async reset mid-operation: immediate return to reset values including the FIFO.

Test Plan:
- Single conversion. Setup: SIZE=12, mode=00, ch_mask=4'b0100, swidth=2, avg_log2=0, modelled input 0xA5C. Start at cycle 0. Required: SAMPLE cycles 1-3, CONVERT 4-15, STORE 16 with eos=1; fifo_data=0xA5C, fifo_ch=2, fifo_empty=0 at cycle 17; busy=0 at 17.
- Scan-once. Setup: ch_mask=4'b1010, ch1=0x100, ch3=0xFFF. Required: FIFO holds (0x100,1) then (0xFFF,3); exactly one eos pulse; ch0 and ch2 never selected.
- Averaging. Setup: avg_log2=2, successive samples 0x800, 0x801, 0x802, 0x803. Required: single entry 0x801 (0x2006>>2); 4 SAMPLE phases observed.
- Overflow. Setup: continuous mode, ch_mask=1, FIFO_DEPTH=4, no reads. Required: level reaches 4 and fifo_full=1; 5th STORE gives ovf=1 with head unchanged. Then fifo_rd coincident with the 6th STORE: level stays 4 and the newest entry is stored.
- Window. Setup: thr_lo=0x200, thr_hi=0x600. Required: input 0x700 -> win pulse; 0x400 -> none; 0x1FF -> pulse; 0x600 -> none.
- Abort and reset. Setup: en dropped at CONVERT cycle 5. Required: IDLE next cycle, no push, no eos, FIFO entries kept. Then wb_rst_ni low mid-SAMPLE: all outputs at reset values immediately and fifo_empty=1.

Source files
------------

// File: rtl/sar_seq_ctrl_if.sv
// sar_seq_ctrl_if: control, analog-front-end and result-FIFO signals of the SAR sequencer.
interface sar_seq_ctrl_if #(
    parameter int SIZE       = 12,
    parameter int NCH        = 4,
    parameter int CH_W       = 2,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic            en;
    logic            start;
    logic [1:0]      mode;
    logic [NCH-1:0]  ch_mask;
    logic [3:0]      swidth;
    logic [1:0]      avg_log2;
    logic [SIZE-1:0] thr_lo;
    logic [SIZE-1:0] thr_hi;
    logic            cmp;
    logic            sample_n;
    logic            dac_rst;
    logic [SIZE-1:0] dac_val;
    logic [CH_W-1:0] ch_sel;
    logic            busy;
    logic            eos;
    logic            win;
    logic            ovf;
    logic            fifo_rd;
    logic [SIZE-1:0] fifo_data;
    logic [CH_W-1:0] fifo_ch;
    logic            fifo_empty;
    logic            fifo_full;
    logic [LW-1:0]   fifo_level;
    modport master (
        output en, start, mode, ch_mask, swidth, avg_log2, thr_lo, thr_hi, cmp, fifo_rd,
        input  sample_n, dac_rst, dac_val, ch_sel, busy, eos, win, ovf,
               fifo_data, fifo_ch, fifo_empty, fifo_full, fifo_level
    );
    modport slave (
        input  en, start, mode, ch_mask, swidth, avg_log2, thr_lo, thr_hi, cmp, fifo_rd,
        output sample_n, dac_rst, dac_val, ch_sel, busy, eos, win, ovf,
               fifo_data, fifo_ch, fifo_empty, fifo_full, fifo_level
    );
endinterface

// File: rtl/sar_seq_ctrl.sv
// sar_seq_ctrl: multi-channel SAR sequencer with power-of-two averaging,
// window compare and a show-ahead result FIFO.
module sar_seq_ctrl #(
    parameter int SIZE       = 12,
    parameter int NCH        = 4,
    parameter int CH_W       = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic           wb_clk_i,
    input logic           wb_rst_ni,
    sar_seq_ctrl_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, STORE} state_t;
    state_t          state, state_n;
    logic [1:0]      mode_q, avg_q;
    logic [NCH-1:0]  mask_q;
    logic [3:0]      sw_q, cnt;
    logic [CH_W-1:0] ch_q, lo_in, lo_q, nx_ch;
    logic            has_nx, single, cont, last_smp, store_ok, push, pop, full;
    logic [SIZE-1:0] part, bitm, code, result;
    logic [SIZE+2:0] acc;
    logic [2:0]      nsamp;
    logic [SIZE-1:0] mem_d [FIFO_DEPTH];
    logic [CH_W-1:0] mem_c [FIFO_DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [AW:0]     level;

    // Downward scan so the lowest matching index wins.
    always_comb begin
        lo_in = '0;
        lo_q = '0;
        nx_ch = '0;
        has_nx = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.ch_mask[i]) lo_in = CH_W'(i);
            if (mask_q[i]) lo_q = CH_W'(i);
            if (mask_q[i] && i > int'(ch_q)) begin
                nx_ch = CH_W'(i);
                has_nx = 1'b1;
            end
        end
    end

    assign single   = mode_q == 2'b00;
    assign cont     = mode_q == 2'b10;
    assign code     = bus.cmp ? (part | bitm) : part;
    assign last_smp = nsamp == 3'((4'd1 << avg_q) - 4'd1);
    assign result   = SIZE'(acc >> avg_q);
    assign store_ok = state == STORE && bus.en;
    assign full     = level == (AW+1)'(FIFO_DEPTH);
    assign pop      = bus.fifo_rd && level != '0;
    assign push     = store_ok && (!full || bus.fifo_rd);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start && |bus.ch_mask) state_n = SAMPLE;
            SAMPLE:  if (cnt == sw_q) state_n = CONVERT;
            CONVERT: if (bitm[0]) state_n = last_smp ? STORE : SAMPLE;
            default: state_n = (!single && (has_nx || cont)) ? SAMPLE : IDLE;
        endcase
        if (!bus.en) state_n = IDLE;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            mode_q <= '0;
            mask_q <= '0;
            sw_q <= '0;
            avg_q <= '0;
            ch_q <= '0;
            cnt <= '0;
            part <= '0;
            bitm <= '0;
            acc <= '0;
            nsamp <= '0;
        end else if (!bus.en || state == IDLE) begin
            cnt <= '0;
            acc <= '0;
            nsamp <= '0;
            if (bus.en && bus.start && |bus.ch_mask) begin
                mode_q <= bus.mode;
                mask_q <= bus.ch_mask;
                sw_q <= bus.swidth;
                avg_q <= bus.avg_log2;
                ch_q <= lo_in;
            end
        end else if (state == SAMPLE) begin
            cnt <= cnt == sw_q ? '0 : cnt + 4'd1;
            part <= '0;
            bitm <= {1'b1, {(SIZE-1){1'b0}}};
        end else if (state == CONVERT) begin
            part <= code;
            bitm <= bitm >> 1;
            if (bitm[0]) begin
                acc <= acc + (SIZE+3)'(code);
                nsamp <= nsamp + 3'd1;
            end
        end else begin
            acc <= '0;
            nsamp <= '0;
            ch_q <= has_nx ? nx_ch : lo_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_d[wp] <= result;
            mem_c[wp] <= ch_q;
        end
    end

    assign bus.sample_n   = state != SAMPLE;
    assign bus.dac_rst    = state == SAMPLE;
    assign bus.dac_val    = state == CONVERT ? (part | bitm) : '0;
    assign bus.ch_sel     = state == IDLE ? '0 : ch_q;
    assign bus.busy       = state != IDLE;
    assign bus.eos        = store_ok && (single || !has_nx);
    assign bus.win        = store_ok && (result < bus.thr_lo || result > bus.thr_hi);
    assign bus.ovf        = store_ok && full && !bus.fifo_rd;
    assign bus.fifo_empty = level == '0;
    assign bus.fifo_full  = full;
    assign bus.fifo_level = level;
    assign bus.fifo_data  = level == '0 ? '0 : mem_d[rp];
    assign bus.fifo_ch    = level == '0 ? '0 : mem_c[rp];
endmodule

// File: tb/tb_sar_seq_ctrl.sv
// tb_sar_seq_ctrl: table vectors, hand-written corner sequences and randomized
// scans checked against an arithmetic model of ideal SAR conversion.
module tb_sar_seq_ctrl;
    localparam int SIZE = 12, NCH = 4, CH_W = 2, FD = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    sar_seq_ctrl_if #(.SIZE(SIZE), .NCH(NCH), .CH_W(CH_W), .FIFO_DEPTH(FD)) io ();
    sar_seq_ctrl #(.SIZE(SIZE), .NCH(NCH), .CH_W(CH_W), .FIFO_DEPTH(FD)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(io)
    );

    typedef struct {
        logic [11:0] v, lo, hi;
        logic [1:0]  avg;
        logic [11:0] exp_d;
        int          exp_w;
    } vec_t;
    vec_t tbl [12];

    logic [11:0] base [NCH];
    logic [11:0] sv [64];
    int sv_base = 0, sv_n = 0;
    logic [11:0] cur = '0;
    logic prev_sn = 1'b1;
    int sp = 0, eos_cnt = 0, win_cnt = 0, ovf_cnt = 0, busy_cyc = 0, smp_cnt = 0;
    int ch_busy [NCH];
    int errs = 0, checks = 0;

    // Analog model: the input held at the start of each sample phase.
    assign io.cmp = cur >= io.dac_val;

    always @(negedge clk) begin
        if (!io.sample_n && prev_sn) begin
            cur <= (sp - sv_base < sv_n) ? sv[sp - sv_base] : base[io.ch_sel];
            sp <= sp + 1;
            smp_cnt <= smp_cnt + 1;
        end
        prev_sn <= io.sample_n;
        eos_cnt <= eos_cnt + (io.eos ? 1 : 0);
        win_cnt <= win_cnt + (io.win ? 1 : 0);
        ovf_cnt <= ovf_cnt + (io.ovf ? 1 : 0);
        if (io.busy) begin
            busy_cyc <= busy_cyc + 1;
            ch_busy[io.ch_sel] <= ch_busy[io.ch_sel] + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic go();
        @(posedge clk); #1 io.start = 1'b1;
        @(posedge clk); #1 io.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (io.busy && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, int'(io.busy), 0);
    endtask

    task automatic cfg(input logic [1:0] md, input logic [3:0] msk, input logic [3:0] sw,
                       input logic [1:0] av, input logic [11:0] lo, input logic [11:0] hi);
        io.mode = md;
        io.ch_mask = msk;
        io.swidth = sw;
        io.avg_log2 = av;
        io.thr_lo = lo;
        io.thr_hi = hi;
        sv_n = 0;
    endtask

    task automatic pop_chk(input string nm, input int d, input int c);
        chk({nm, "_data"}, int'(io.fifo_data), d);
        chk({nm, "_ch"}, int'(io.fifo_ch), c);
        io.fifo_rd = 1'b1;
        @(posedge clk); #1 io.fifo_rd = 1'b0;
    endtask

    logic [31:0] smp_v, rst_v, eos_v, busy_v;
    logic [11:0] dv4, dv5, d17, lo, hi, v;
    logic [1:0]  ch17, av, md;
    logic [3:0]  m, sw;
    logic        e17;
    int chbad, k, n, e0, w0, o0, b0, s0, lat, wexp, sum, r;
    int cb0 [NCH];
    logic [11:0] exp_d [$];
    int exp_c [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{12'hA5C, 12'h000, 12'hFFF, 2'd0, 12'hA5C, 0};
        tbl[1]  = '{12'h700, 12'h200, 12'h600, 2'd0, 12'h700, 1};
        tbl[2]  = '{12'h400, 12'h200, 12'h600, 2'd0, 12'h400, 0};
        tbl[3]  = '{12'h1FF, 12'h200, 12'h600, 2'd0, 12'h1FF, 1};
        tbl[4]  = '{12'h600, 12'h200, 12'h600, 2'd0, 12'h600, 0};
        tbl[5]  = '{12'h200, 12'h200, 12'h600, 2'd0, 12'h200, 0};
        tbl[6]  = '{12'h601, 12'h200, 12'h600, 2'd1, 12'h601, 1};
        tbl[7]  = '{12'h000, 12'h000, 12'hFFF, 2'd0, 12'h000, 0};
        tbl[8]  = '{12'hFFF, 12'h000, 12'hFFF, 2'd2, 12'hFFF, 0};
        tbl[9]  = '{12'h400, 12'h600, 12'h200, 2'd0, 12'h400, 1};
        tbl[10] = '{12'h123, 12'h100, 12'h200, 2'd3, 12'h123, 0};
        tbl[11] = '{12'h555, 12'h556, 12'hFFF, 2'd1, 12'h555, 1};
        for (int i = 0; i < NCH; i++) base[i] = '0;
        io.en = 1'b1;
        io.start = 1'b0;
        io.fifo_rd = 1'b0;
        cfg(2'b00, 4'b0000, 4'd0, 2'd0, 12'h000, 12'hFFF);
        #12;
        chk("rst_busy", int'(io.busy), 0);
        chk("rst_sample_n", int'(io.sample_n), 1);
        chk("rst_dac_rst", int'(io.dac_rst), 0);
        chk("rst_dac_val", int'(io.dac_val), 0);
        chk("rst_ch_sel", int'(io.ch_sel), 0);
        chk("rst_pulses", int'({io.eos, io.win, io.ovf}), 0);
        chk("rst_empty", int'(io.fifo_empty), 1);
        chk("rst_level", int'(io.fifo_level), 0);
        chk("rst_data", int'(io.fifo_data), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        go();
        chk("start_mask0_ignored", int'(io.busy), 0);
        cfg(2'b00, 4'b0001, 4'd0, 2'd0, 12'h000, 12'hFFF);
        io.en = 1'b0;
        go();
        chk("start_en0_ignored", int'(io.busy), 0);
        io.en = 1'b1;

        // Single conversion with exact cycle timing.
        cfg(2'b00, 4'b0100, 4'd2, 2'd0, 12'h000, 12'hFFF);
        base[2] = 12'hA5C;
        smp_v = '0; rst_v = '0; eos_v = '0; busy_v = '0; chbad = 0;
        go();
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (!io.sample_n) smp_v[c] = 1'b1;
            if (io.dac_rst) rst_v[c] = 1'b1;
            if (io.eos) eos_v[c] = 1'b1;
            if (io.busy) busy_v[c] = 1'b1;
            if (io.busy && io.ch_sel != 2'd2) chbad++;
            if (c == 4) dv4 = io.dac_val;
            if (c == 5) dv5 = io.dac_val;
            if (c == 17) begin
                d17 = io.fifo_data;
                ch17 = io.fifo_ch;
                e17 = io.fifo_empty;
            end
        end
        chk("single_sample_cycles", int'(smp_v), 32'hE);
        chk("single_dac_rst_cycles", int'(rst_v), 32'hE);
        chk("single_eos_cycle", int'(eos_v), 32'h10000);
        chk("single_busy_cycles", int'(busy_v), 32'h1FFFE);
        chk("single_ch_sel", chbad, 0);
        chk("single_dac_k0", int'(dv4), 12'h800);
        chk("single_dac_k1", int'(dv5), 12'hC00);
        chk("single_data", int'(d17), 12'hA5C);
        chk("single_ch", int'(ch17), 2);
        chk("single_empty", int'(e17), 0);
        @(posedge clk); #1 io.fifo_rd = 1'b1;
        @(posedge clk); #1 io.fifo_rd = 1'b0;
        chk("single_pop_empty", int'(io.fifo_empty), 1);

        for (int i = 0; i < 12; i++) begin
            cfg(2'b00, 4'b0001, 4'(i % 4), tbl[i].avg, tbl[i].lo, tbl[i].hi);
            base[0] = tbl[i].v;
            w0 = win_cnt;
            e0 = eos_cnt;
            go();
            wait_idle($sformatf("tbl%0d_idle", i));
            chk($sformatf("tbl%0d_win", i), win_cnt - w0, tbl[i].exp_w);
            chk($sformatf("tbl%0d_eos", i), eos_cnt - e0, 1);
            pop_chk($sformatf("tbl%0d", i), int'(tbl[i].exp_d), 0);
        end

        // Scan-once over channels 1 and 3.
        cfg(2'b01, 4'b1010, 4'd1, 2'd0, 12'h000, 12'hFFF);
        base[1] = 12'h100;
        base[3] = 12'hFFF;
        cb0 = ch_busy;
        e0 = eos_cnt;
        go();
        wait_idle("scan_idle");
        chk("scan_eos", eos_cnt - e0, 1);
        chk("scan_level", int'(io.fifo_level), 2);
        chk("scan_ch0_unused", ch_busy[0] - cb0[0], 0);
        chk("scan_ch2_unused", ch_busy[2] - cb0[2], 0);
        chk("scan_ch1_cycles", ch_busy[1] - cb0[1], 15);
        chk("scan_ch3_cycles", ch_busy[3] - cb0[3], 15);
        pop_chk("scan_e0", 12'h100, 1);
        pop_chk("scan_e1", 12'hFFF, 3);

        // Four-sample averaging with distinct samples.
        cfg(2'b00, 4'b0001, 4'd0, 2'd2, 12'h000, 12'hFFF);
        sv[0] = 12'h800; sv[1] = 12'h801; sv[2] = 12'h802; sv[3] = 12'h803;
        sv_base = sp;
        sv_n = 4;
        s0 = smp_cnt;
        b0 = busy_cyc;
        go();
        wait_idle("avg_idle");
        chk("avg_phases", smp_cnt - s0, 4);
        chk("avg_busy", busy_cyc - b0, 53);
        chk("avg_level", int'(io.fifo_level), 1);
        pop_chk("avg", 12'h801, 0);

        // Continuous mode filling the FIFO, dropping one result, then a coincident read.
        cfg(2'b10, 4'b0001, 4'd0, 2'd0, 12'h000, 12'hFFF);
        for (int i = 0; i < 8; i++) sv[i] = 12'(i + 1);
        sv_base = sp;
        sv_n = 8;
        o0 = ovf_cnt;
        go();
        k = 0;
        n = 0;
        while (k < 5 && n < 1000) begin
            @(negedge clk);
            n++;
            if (io.eos) k++;
        end
        chk("ovf_reach_store5", k, 5);
        chk("ovf_pulse", int'(io.ovf), 1);
        chk("ovf_full", int'(io.fifo_full), 1);
        chk("ovf_level", int'(io.fifo_level), 4);
        repeat (14) @(posedge clk);
        #1 io.fifo_rd = 1'b1;
        @(negedge clk);
        chk("ovf_store6_eos", int'(io.eos), 1);
        chk("ovf_store6_no_ovf", int'(io.ovf), 0);
        chk("ovf_head_kept", int'(io.fifo_data), 1);
        @(posedge clk); #1 io.fifo_rd = 1'b0;
        io.en = 1'b0;
        chk("ovf_level_after_rdpush", int'(io.fifo_level), 4);
        @(posedge clk); #1 io.en = 1'b1;
        chk("ovf_stopped", int'(io.busy), 0);
        chk("ovf_count", ovf_cnt - o0, 1);
        pop_chk("ovf_e0", 2, 0);
        pop_chk("ovf_e1", 3, 0);
        pop_chk("ovf_e2", 4, 0);
        pop_chk("ovf_e3", 6, 0);
        chk("ovf_drained", int'(io.fifo_empty), 1);

        // Abort during CONVERT keeps the FIFO intact.
        cfg(2'b00, 4'b0001, 4'd2, 2'd0, 12'h000, 12'hFFF);
        base[0] = 12'h333;
        go();
        wait_idle("abort_pre_idle");
        cfg(2'b00, 4'b0010, 4'd2, 2'd0, 12'h000, 12'hFFF);
        base[1] = 12'h777;
        e0 = eos_cnt;
        go();
        repeat (8) @(posedge clk);
        #1;
        chk("abort_busy_before", int'(io.busy), 1);
        io.en = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle", int'(io.busy), 0);
        chk("abort_sample_n", int'(io.sample_n), 1);
        chk("abort_dac_val", int'(io.dac_val), 0);
        chk("abort_ch_sel", int'(io.ch_sel), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_eos", eos_cnt - e0, 0);
        chk("abort_level", int'(io.fifo_level), 1);
        pop_chk("abort_rd_en0", 12'h333, 0);
        chk("abort_rd_en0_empty", int'(io.fifo_empty), 1);
        io.en = 1'b1;

        // Asynchronous reset in the middle of SAMPLE clears everything.
        cfg(2'b00, 4'b0001, 4'd0, 2'd0, 12'h000, 12'hFFF);
        base[0] = 12'h444;
        go();
        wait_idle("areset_pre_idle");
        cfg(2'b00, 4'b0100, 4'd8, 2'd0, 12'h000, 12'hFFF);
        go();
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("areset_busy", int'(io.busy), 0);
        chk("areset_sample_n", int'(io.sample_n), 1);
        chk("areset_dac_rst", int'(io.dac_rst), 0);
        chk("areset_ch_sel", int'(io.ch_sel), 0);
        chk("areset_empty", int'(io.fifo_empty), 1);
        chk("areset_level", int'(io.fifo_level), 0);
        chk("areset_data", int'(io.fifo_data), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized scan-once runs against an arithmetic model.
        for (int it = 0; it < 10; it++) begin
            m = 4'($urandom_range(1, 15));
            sw = 4'($urandom_range(0, 15));
            av = 2'($urandom_range(0, 3));
            lo = 12'($urandom_range(0, 4095));
            hi = 12'($urandom_range(0, 4095));
            md = $urandom_range(0, 1) != 0 ? 2'b11 : 2'b01;
            cfg(md, m, sw, av, lo, hi);
            exp_d.delete();
            exp_c.delete();
            n = 0;
            wexp = 0;
            lat = 0;
            for (int c = 0; c < NCH; c++) begin
                if (m[c]) begin
                    sum = 0;
                    for (int s = 0; s < (1 << av); s++) begin
                        v = 12'($urandom_range(0, 4095));
                        sv[n] = v;
                        n++;
                        sum += int'(v);
                    end
                    r = sum / (1 << av);
                    exp_d.push_back(12'(r));
                    exp_c.push_back(c);
                    if (r < int'(lo) || r > int'(hi)) wexp++;
                    lat += (1 << av) * (int'(sw) + 1 + SIZE) + 1;
                end
            end
            sv_base = sp;
            sv_n = n;
            e0 = eos_cnt;
            w0 = win_cnt;
            b0 = busy_cyc;
            go();
            wait_idle($sformatf("rnd%0d_idle", it));
            chk($sformatf("rnd%0d_eos", it), eos_cnt - e0, 1);
            chk($sformatf("rnd%0d_win", it), win_cnt - w0, wexp);
            chk($sformatf("rnd%0d_busy", it), busy_cyc - b0, lat);
            chk($sformatf("rnd%0d_level", it), int'(io.fifo_level), exp_d.size());
            for (int j = 0; j < exp_d.size(); j++)
                pop_chk($sformatf("rnd%0d_e%0d", it, j), int'(exp_d[j]), exp_c[j]);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
